pipe_intr_ctrl: RTL and testbench
=================================

Name: pipe_intr_ctrl

Overview:
Pipeline control block for the interrupt-capable 5-stage CPU. It generates the stall that freezes the PC and the IF/ID register, and the flush that clears IF/ID. It also selects the next-PC source and sequences interrupt entry and return, capturing the EPC.
It sits beside the IF/ID register and the PC mux, driven by ID/EX hazard information.

Parameters:
VECTOR, 32'h0000_0008, handler entry address driven when pc_sel selects the vector.
PC_W, 32, width of PC/EPC values.

Ports:
clk  in  1  pipeline clock, rising edge.
clrn  in  1  asynchronous active-low reset.
intr  in  1  external interrupt request, level-sensitive.
if_pc  in  PC_W  PC of instruction currently in IF.
id_rs  in  5  rs field of ID instruction.
id_rt  in  5  rt field of ID instruction.
id_use_rs  in  1  ID instruction reads rs.
id_use_rt  in  1  ID instruction reads rt.
id_is_branch  in  1  ID instruction is a branch/jump (IF holds its delay slot).
id_is_eret  in  1  ID instruction is eret.
ex_wreg  in  1  EX instruction writes a register.
ex_m2reg  in  1  EX instruction is a load.
ex_rn  in  5  EX destination register.
stall  out  1  freeze PC and IF/ID (load-use).
flush_ifid  out  1  clear IF/ID to zero (nop) on the next edge.
pc_sel  out  2  0 = sequential/branch path, 1 = VECTOR, 2 = EPC; 3 is unused.
vector  out  PC_W  constant VECTOR.
epc  out  PC_W  saved return PC.
ie  out  1  interrupt enable.
intr_ack  out  1  one-cycle pulse on interrupt acceptance.

Behaviour:
- Reset (clrn=0, async): state=IDLE; epc=0; ie=1; stall, flush_ifid and intr_ack are 0; pc_sel=0.
- stall is combinational and independent of state:
  - stall = ex_wreg & ex_m2reg & (ex_rn!=0) & ((id_use_rs & ex_rn==id_rs) | (id_use_rt & ex_rn==id_rt)).
- take is combinational: take = (state==IDLE) & intr_s & ie & !stall & !id_is_branch.
  - intr_s is intr, or the synchronised intr when the optional feature is enabled.
  - Stall and delay slot both block take; the request stays pending and is re-evaluated each cycle.
- States:
  - IDLE:
    - If take: same cycle pc_sel=1, flush_ifid=1, intr_ack=1.
    - On the edge: epc<=if_pc (the flushed IF instruction re-executes on return), ie<=0, state->HANDLER.
    - Otherwise all three outputs are 0.
    - id_is_eret in IDLE is ignored (pc_sel stays 0).
  - HANDLER:
    - intr is ignored.
    - If id_is_eret & !stall: same cycle pc_sel=2, flush_ifid=1.
    - On the edge: ie<=1, state->RETURN.
    - eret held by stall waits until stall drops.
  - RETURN: one-cycle guard.
    - No take is possible, so the first instruction at EPC reaches IF/ID.
    - Outputs are 0; state->IDLE unconditionally.
- Latency:
  - Interrupt acceptance to handler fetch is 1 cycle (vector loaded into PC on the accept edge).
  - eret to return fetch is 1 cycle.
- stall and flush_ifid are never both 1 (take and eret both require !stall).
- epc changes only on a take edge; it holds through HANDLER and RETURN.
- Async reset mid-HANDLER returns to IDLE with ie=1; the pending handler is abandoned.

Optional Feature:
- Macro INTR_SYNC_EN.
- Defined: intr passes through a 2-flop synchroniser (reset to 0) before use, adding 2 cycles of request latency.
- Undefined: intr is used directly; the source must be synchronous to clk.

Decomposition:
- Shared package holds:
  - pc_sel encodings PCSEL_SEQ=0, PCSEL_VEC=1, PCSEL_EPC=2;
  - state encodings ST_IDLE, ST_HANDLER, ST_RETURN;
  - default VECTOR constant.
- One sub-module, load_use_detect: purely combinational stall equation. Reused by the forwarding unit.

Test Plan:
- Load-use stall: ex_wreg=1, ex_m2reg=1, ex_rn=5, id_rs=5, id_use_rs=1 -> stall=1, flush_ifid=0. With ex_rn=0 -> stall=0.
- Interrupt take: IDLE, ie=1, intr=1, if_pc=32'h40, no stall/branch:
  - same cycle pc_sel=1, flush_ifid=1, intr_ack=1;
  - next cycle epc=32'h40, ie=0, state HANDLER, intr_ack=0.
- Blocked take: intr=1 while id_is_branch=1 -> no ack. Next cycle id_is_branch=0, if_pc=32'h48 -> ack, epc=32'h48.
- Stall precedence: intr=1 with load-use stall active for 2 cycles -> ack only in the first cycle after stall drops.
- Return sequence: in HANDLER, id_is_eret=1 -> pc_sel=2, flush_ifid=1. Next cycle RETURN with ie=1 and intr=1 ignored. Following cycle IDLE and take fires.
- Reset mid-handler: clrn pulsed low in HANDLER -> immediately state IDLE, epc=0, ie=1, all pulses 0.

Source files
------------

// File: rtl/pipe_intr_ctrl_pkg.sv
// Shared encodings for the pipeline/interrupt control slice: pc_sel values,
// controller state codes and the default handler entry address.
// Imported by the interface, the top and the testbench.
package pipe_intr_ctrl_pkg;

  // Next-PC source select driven to the PC mux
  localparam logic [1:0] PCSEL_SEQ = 2'd0;  // sequential / branch path
  localparam logic [1:0] PCSEL_VEC = 2'd1;  // interrupt vector
  localparam logic [1:0] PCSEL_EPC = 2'd2;  // return to saved PC

  // Controller state codes (code 3 is unreachable and decodes as IDLE)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HANDLER = 2'd1;
  localparam logic [1:0] ST_RETURN  = 2'd2;

  // Default handler entry address
  localparam logic [31:0] VECTOR_DEFAULT = 32'h0000_0008;

endpackage

// File: rtl/pipe_intr_ctrl_if.sv
// Hazard/interrupt inputs from the pipeline and control outputs back to it.
// master: pipeline side (drives ID/EX hazard info, IF PC, interrupt line).
// slave: the control block (drives stall, flush, pc_sel, epc, ie, ack).
interface pipe_intr_ctrl_if #(
  parameter int PC_W = 32
);
  logic            intr;
  logic [PC_W-1:0] if_pc;
  logic [4:0]      id_rs;
  logic [4:0]      id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_is_branch;
  logic            id_is_eret;
  logic            ex_wreg;
  logic            ex_m2reg;
  logic [4:0]      ex_rn;

  logic            stall;
  logic            flush_ifid;
  logic [1:0]      pc_sel;
  logic [PC_W-1:0] vector;
  logic [PC_W-1:0] epc;
  logic            ie;
  logic            intr_ack;

  modport master (
    output intr, if_pc, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_is_eret, ex_wreg, ex_m2reg, ex_rn,
    input  stall, flush_ifid, pc_sel, vector, epc, ie, intr_ack
  );

  modport slave (
    input  intr, if_pc, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_is_eret, ex_wreg, ex_m2reg, ex_rn,
    output stall, flush_ifid, pc_sel, vector, epc, ie, intr_ack
  );
endinterface

// File: rtl/pipe_intr_ctrl_load_use_detect.sv
// Load-use hazard detector: EX load whose destination feeds an ID source.
// Latency: purely combinational, zero cycles.
// Backpressure: its output is the stall itself; no flow control of its own.
module load_use_detect (
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       stall
);
  // r0 is hardwired zero, so a load targeting it never creates a hazard
  assign stall = ex_wreg & ex_m2reg & (ex_rn != 5'd0) &
                 ((id_use_rs & (ex_rn == id_rs)) | (id_use_rt & (ex_rn == id_rt)));
endmodule

// File: rtl/pipe_intr_ctrl.sv
// Pipeline control: load-use stall, IF/ID flush, next-PC select, interrupt entry/return, EPC.
// Latency: stall/flush/pc_sel are same-cycle; interrupt accept or eret -> new fetch after 1 edge.
// Backpressure: a stall or a branch delay slot holds an interrupt pending; a stall holds eret.
// Build option: define INTR_SYNC_EN to pass intr through a 2-flop synchroniser (+2 cycles).
module pipe_intr_ctrl
  import pipe_intr_ctrl_pkg::*;
#(
  parameter int              PC_W   = 32,
  parameter logic [PC_W-1:0] VECTOR = PC_W'(VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            clrn,
  pipe_intr_ctrl_if.slave bus
);

  logic [1:0]      state;
  logic [PC_W-1:0] epc_q;
  logic            ie_q;
  logic            stall;
  logic            intr_s;
  logic            take;
  logic            eret_go;
  logic [1:0]      pc_sel;
  logic            flush_ifid;
  logic            intr_ack;

  load_use_detect u_load_use_detect (
    .ex_wreg   (bus.ex_wreg),
    .ex_m2reg  (bus.ex_m2reg),
    .ex_rn     (bus.ex_rn),
    .id_rs     (bus.id_rs),
    .id_rt     (bus.id_rt),
    .id_use_rs (bus.id_use_rs),
    .id_use_rt (bus.id_use_rt),
    .stall     (stall)
  );

`ifdef INTR_SYNC_EN
  logic [1:0] intr_sync;

  // Two-flop synchroniser for an interrupt line from another clock domain
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) intr_sync <= 2'b00;
    else       intr_sync <= {intr_sync[0], bus.intr};
  end

  assign intr_s = intr_sync[1];
`else
  assign intr_s = bus.intr;
`endif

  // Never accept inside a delay slot or while stalled: EPC must name an
  // instruction that can simply be refetched.
  assign take    = (state == ST_IDLE) & intr_s & ie_q & ~stall & ~bus.id_is_branch;
  assign eret_go = (state == ST_HANDLER) & bus.id_is_eret & ~stall;

  // Same-cycle redirect: vector on accept, EPC on eret, else sequential
  always_comb begin
    pc_sel     = PCSEL_SEQ;
    flush_ifid = 1'b0;
    intr_ack   = 1'b0;
    if (take) begin
      pc_sel     = PCSEL_VEC;
      flush_ifid = 1'b1;
      intr_ack   = 1'b1;
    end else if (eret_go) begin
      pc_sel     = PCSEL_EPC;
      flush_ifid = 1'b1;
    end
  end

  // Interrupt sequencing; RETURN is a one-cycle guard so the instruction at
  // EPC reaches IF/ID before another interrupt can be accepted.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_IDLE;
      epc_q <= '0;
      ie_q  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            epc_q <= bus.if_pc;
            ie_q  <= 1'b0;
            state <= ST_HANDLER;
          end
        end
        ST_HANDLER: begin
          if (eret_go) begin
            ie_q  <= 1'b1;
            state <= ST_RETURN;
          end
        end
        ST_RETURN: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall      = stall;
  assign bus.flush_ifid = flush_ifid;
  assign bus.pc_sel     = pc_sel;
  assign bus.vector     = VECTOR;
  assign bus.epc        = epc_q;
  assign bus.ie         = ie_q;
  assign bus.intr_ack   = intr_ack;

endmodule

// File: tb/tb_pipe_intr_ctrl.sv
// Self-checking bench for pipe_intr_ctrl: directed scenarios then randomized
// traffic, all compared against a cycle-level reference model of the rules.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pipe_intr_ctrl;
  import pipe_intr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  pipe_intr_ctrl_if #(.PC_W(32)) bus ();

  pipe_intr_ctrl #(.PC_W(32), .VECTOR(32'h0000_0008)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: where the controller is in its interrupt life-cycle
  // (0 = running normally, 1 = inside handler, 2 = first cycle back).
  int          m_mode;
  logic [31:0] m_epc;
  logic        m_ie;
  logic        m_h1, m_h2;   // intr seen one / two edges ago

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ref_stall();
    logic hit_rs, hit_rt;
    hit_rs = bus.id_use_rs && (bus.ex_rn == bus.id_rs);
    hit_rt = bus.id_use_rt && (bus.ex_rn == bus.id_rt);
    return bus.ex_wreg && bus.ex_m2reg && (bus.ex_rn != 0) && (hit_rs || hit_rt);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_epc  = 32'h0;
    m_ie   = 1'b1;
    m_h1   = 1'b0;
    m_h2   = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.intr         = 1'b0;
    bus.if_pc        = 32'h0;
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.id_use_rs    = 1'b0;
    bus.id_use_rt    = 1'b0;
    bus.id_is_branch = 1'b0;
    bus.id_is_eret   = 1'b0;
    bus.ex_wreg      = 1'b0;
    bus.ex_m2reg     = 1'b0;
    bus.ex_rn        = 5'd0;
  endtask

  task automatic set_load_use(input logic on);
    bus.ex_wreg   = on;
    bus.ex_m2reg  = on;
    bus.ex_rn     = on ? 5'd7 : 5'd0;
    bus.id_rt     = 5'd7;
    bus.id_use_rt = on;
  endtask

  // Check this cycle's outputs against the model, then advance one clock.
  task automatic run_cycle(input string tag);
    logic       st, ireq, tk, er;
    logic [1:0] sel;
    #1;
    st = ref_stall();
`ifdef INTR_SYNC_EN
    ireq = m_h2;
`else
    ireq = bus.intr;
`endif
    tk  = (m_mode == 0) && ireq && m_ie && !st && !bus.id_is_branch;
    er  = (m_mode == 1) && bus.id_is_eret && !st;
    sel = tk ? PCSEL_VEC : (er ? PCSEL_EPC : PCSEL_SEQ);
    chk({tag, ".stall"},  32'(bus.stall),      32'(st));
    chk({tag, ".flush"},  32'(bus.flush_ifid), 32'(tk || er));
    chk({tag, ".pc_sel"}, 32'(bus.pc_sel),     32'(sel));
    chk({tag, ".ack"},    32'(bus.intr_ack),   32'(tk));
    chk({tag, ".epc"},    bus.epc,             m_epc);
    chk({tag, ".ie"},     32'(bus.ie),         32'(m_ie));
    chk({tag, ".vector"}, bus.vector,          32'h0000_0008);
    chk({tag, ".excl"},   32'(bus.stall && bus.flush_ifid), 32'h0);
    @(posedge clk);
    if (tk) begin
      m_epc  = bus.if_pc;
      m_ie   = 1'b0;
      m_mode = 1;
    end else if (er) begin
      m_ie   = 1'b1;
      m_mode = 2;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end
    m_h2 = m_h1;
    m_h1 = bus.intr;
    @(negedge clk);
  endtask

  // Assert reset on a falling edge, check the immediate values, release a cycle later.
  task automatic do_reset(input string tag);
    clrn = 1'b0;
    clear_inputs();
    #1;
    chk({tag, ".epc"},    bus.epc,              32'h0);
    chk({tag, ".ie"},     32'(bus.ie),          32'h1);
    chk({tag, ".pc_sel"}, 32'(bus.pc_sel),      32'h0);
    chk({tag, ".flush"},  32'(bus.flush_ifid),  32'h0);
    chk({tag, ".ack"},    32'(bus.intr_ack),    32'h0);
    chk({tag, ".stall"},  32'(bus.stall),       32'h0);
    model_reset();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic drive_random();
    bus.intr         = ($urandom_range(0, 1) == 1);
    bus.if_pc        = {$urandom_range(0, 32'h0000_ffff), 2'b00};
    bus.id_rs        = 5'($urandom_range(0, 3));
    bus.id_rt        = 5'($urandom_range(0, 3));
    bus.id_use_rs    = ($urandom_range(0, 1) == 1);
    bus.id_use_rt    = ($urandom_range(0, 1) == 1);
    bus.id_is_branch = ($urandom_range(0, 3) == 0);
    bus.id_is_eret   = ($urandom_range(0, 4) == 0);
    bus.ex_wreg      = ($urandom_range(0, 9) < 7);
    bus.ex_m2reg     = ($urandom_range(0, 1) == 1);
    bus.ex_rn        = 5'($urandom_range(0, 3));
  endtask

  initial begin
    clrn = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset("rst");

    // Load-use stall, then the r0 exception
    bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_rn = 5'd5;
    bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
    run_cycle("lu");
    bus.ex_rn = 5'd0;
    run_cycle("lu_r0");
    clear_inputs();

    // Delay slot blocks the take; accepted the following cycle
    bus.intr = 1'b1; bus.id_is_branch = 1'b1; bus.if_pc = 32'h44;
    run_cycle("blk");
    bus.id_is_branch = 1'b0; bus.if_pc = 32'h48;
    for (int i = 0; i < 3 && m_mode == 0; i++) run_cycle("blk_take");
    run_cycle("hnd");

    // eret held by stall, then return with intr pending and the RETURN guard
    bus.id_is_eret = 1'b1;
    set_load_use(1'b1);
    run_cycle("eret_st0");
    run_cycle("eret_st1");
    set_load_use(1'b0);
    run_cycle("eret");
    bus.id_is_eret = 1'b0;
    bus.if_pc = 32'h40;
    run_cycle("ret_guard");
    run_cycle("idle_take");
    run_cycle("hnd2");

    // Reset in the middle of a handler
    do_reset("rst_mid");

    // Stall holds the request pending for two cycles
    bus.intr = 1'b1; bus.if_pc = 32'h80;
    set_load_use(1'b1);
    run_cycle("st_hold0");
    run_cycle("st_hold1");
    set_load_use(1'b0);
    for (int i = 0; i < 4; i++) run_cycle("st_release");

    // Randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        drive_random();
        run_cycle("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
